// File: rtl/delay_line_if.sv
// Handshake and sample-stream bundle for the programmable delay line.
// The slave side is the delay line; the master side is its user.
interface delay_line_if #(
   parameter int WIDTH = 16,
   parameter int DW    = 7
);
   logic                    cfg_valid;
   logic [DW-1:0]           cfg_delay;
   logic                    cfg_ready;
   logic                    cfg_err;
   logic                    in_valid;
   logic signed [WIDTH-1:0] in_data;
   logic                    out_valid;
   logic signed [WIDTH-1:0] out_data;
   logic [DW-1:0]           cur_delay;
   logic                    busy;

   modport master (
      output cfg_valid, cfg_delay, in_valid, in_data,
      input  cfg_ready, cfg_err, out_valid, out_data, cur_delay, busy
   );

   modport slave (
      input  cfg_valid, cfg_delay, in_valid, in_data,
      output cfg_ready, cfg_err, out_valid, out_data, cur_delay, busy
   );
endinterface

// File: rtl/delay_line_ctrl.sv
// Runtime-programmable delay line: circular sample buffer plus a retune FSM that
// withholds output until enough history exists for the delay in force.
module delay_line_ctrl #(
   parameter int WIDTH         = 16,
   parameter int MAX_DELAY     = 64,
   parameter int DEFAULT_DELAY = 1,
   parameter int FLUSH_ON_CFG  = 0
) (
   input  logic        clk,
   input  logic        rst,
   delay_line_if.slave bus
);
   localparam int DW = $clog2(MAX_DELAY + 1);
   localparam int AW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

   localparam logic [1:0] S_FILL  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_APPLY = 2'd2;

   localparam logic [DW-1:0] MAX_D    = DW'(MAX_DELAY);
   localparam logic [DW-1:0] DEF_D    = DW'(DEFAULT_DELAY);
   localparam logic [DW-1:0] LAST_PTR = DW'(MAX_DELAY - 1);

   logic [1:0]              state;
   logic [DW-1:0]           fill;
   logic [DW-1:0]           fill_nxt;
   logic [DW-1:0]           wr_ptr;
   logic [DW-1:0]           cur_delay;
   logic [DW-1:0]           cfg_clamped;
   logic [AW-1:0]           rd_addr;
   logic                    cfg_acc;
   logic                    clamp;
   logic                    emit;
   logic                    out_valid_p1;
   logic                    cfg_err_p1;
   logic signed [WIDTH-1:0] out_data_p1;
   logic signed [WIDTH-1:0] mem [MAX_DELAY];

   assign cfg_acc     = bus.cfg_valid && (state != S_APPLY);
   assign clamp       = bus.cfg_delay > MAX_D;
   assign cfg_clamped = clamp ? MAX_D : bus.cfg_delay;
   // A sample is emitted only if the history before it already covers the delay.
   assign emit        = bus.in_valid && (state != S_APPLY) && (fill >= cur_delay);

   always_comb begin
      fill_nxt = fill;
      if (bus.in_valid && (fill != MAX_D))
         fill_nxt = fill + DW'(1);
      if (cfg_acc && (FLUSH_ON_CFG != 0))
         fill_nxt = '0;
   end

   // Read-before-write: D == MAX_DELAY lands on the slot about to be overwritten.
   always_comb begin
      if (wr_ptr >= cur_delay)
         rd_addr = AW'(wr_ptr - cur_delay);
      else
         rd_addr = AW'(wr_ptr + (MAX_D - cur_delay));
   end

   always_ff @(posedge clk) begin
      if (bus.in_valid)
         mem[AW'(wr_ptr)] <= bus.in_data;
   end

   // Stage p1: registered output and control state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= (DEFAULT_DELAY == 0) ? S_RUN : S_FILL;
         fill         <= '0;
         wr_ptr       <= '0;
         cur_delay    <= DEF_D;
         cfg_err_p1   <= 1'b0;
         out_valid_p1 <= 1'b0;
         out_data_p1  <= '0;
      end else begin
         fill         <= fill_nxt;
         cfg_err_p1   <= cfg_acc && clamp;
         out_valid_p1 <= emit;
         if (emit)
            out_data_p1 <= (cur_delay == '0) ? bus.in_data : mem[rd_addr];
         if (bus.in_valid)
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + DW'(1);
         if (cfg_acc) begin
            cur_delay <= cfg_clamped;
            state     <= S_APPLY;
         end else if (fill_nxt >= cur_delay) begin
            state     <= S_RUN;
         end else begin
            state     <= S_FILL;
         end
      end
   end

   assign bus.cfg_ready = (state != S_APPLY);
   assign bus.busy      = (state != S_RUN);
   assign bus.cur_delay = cur_delay;
   assign bus.cfg_err   = cfg_err_p1;
   assign bus.out_valid = out_valid_p1;
   assign bus.out_data  = out_data_p1;
endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed bench for delay_line_ctrl (MAX_DELAY=8, DEFAULT_DELAY=3, no flush).
// Expected values are hand-derived from the sample indices of each sequence.
module tb_delay_line_ctrl;
   localparam int WIDTH = 16;
   localparam int DW    = 4;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   delay_line_if #(.WIDTH(WIDTH), .DW(DW)) bus ();

   delay_line_ctrl #(
      .WIDTH(WIDTH), .MAX_DELAY(8), .DEFAULT_DELAY(3), .FLUSH_ON_CFG(0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int d);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(d);
      tick();
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      tick();
   endtask

   task automatic cfg(input int d);
      bus.cfg_valid = 1'b1;
      bus.cfg_delay = 4'(d);
      bus.in_valid  = 1'b0;
      tick();
      bus.cfg_valid = 1'b0;
   endtask

   task automatic do_reset();
      bus.cfg_valid = 1'b0;
      bus.in_valid  = 1'b0;
      rst = 1'b0;
      tick();
      chk("rst_vld",   32'(bus.out_valid), 0);
      chk("rst_dat",   32'(bus.out_data),  0);
      chk("rst_dly",   32'(bus.cur_delay), 3);
      chk("rst_rdy",   32'(bus.cfg_ready), 1);
      chk("rst_busy",  32'(bus.busy),      1);
      chk("rst_err",   32'(bus.cfg_err),   0);
      tick();
      rst = 1'b1;
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      bus.cfg_delay = '0;
      bus.in_data   = '0;

      // Continuous stream at the default delay of 3
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         push(k);
         chk("t1_vld",  32'(bus.out_valid), 32'(k >= 4));
         chk("t1_busy", 32'(bus.busy),      32'(k < 3));
         if (k >= 4) chk("t1_dat", 32'(bus.out_data), 32'(k - 3));
      end
      idle();

      // Delay 2 with alternating strobes; gaps must hold data
      do_reset();
      cfg(2);
      chk("t2_rdy",  32'(bus.cfg_ready), 0);
      chk("t2_dly",  32'(bus.cur_delay), 2);
      idle();
      chk("t2_busy", 32'(bus.busy), 1);
      for (int n = 1; n <= 6; n++) begin
         push(9 + n);
         chk("t2_vld", 32'(bus.out_valid), 32'(n >= 3));
         if (n >= 3) chk("t2_dat", 32'(bus.out_data), 32'(n + 7));
         idle();
         chk("t2_gap_vld", 32'(bus.out_valid), 0);
         chk("t2_gap_dat", 32'(bus.out_data), (n >= 3) ? 32'(n + 7) : 0);
      end

      // Retune 2 -> 5 from RUN with only 2 samples of history
      do_reset();
      cfg(2);
      idle();
      push(100);
      push(101);
      idle();
      chk("t3_run", 32'(bus.busy), 0);
      cfg(5);
      chk("t3_rdy", 32'(bus.cfg_ready), 0);
      chk("t3_dly", 32'(bus.cur_delay), 5);
      chk("t3_err", 32'(bus.cfg_err),   0);
      idle();
      chk("t3_fill", 32'(bus.busy), 1);
      for (int j = 2; j <= 10; j++) begin
         push(100 + j);
         chk("t3_vld",  32'(bus.out_valid), 32'(j >= 5));
         chk("t3_busy", 32'(bus.busy),      32'(j < 4));
         if (j >= 5) chk("t3_dat", 32'(bus.out_data), 32'(95 + j));
      end
      idle();

      // Over-range request clamps to 8 with a one-cycle error pulse
      cfg(11);
      chk("t4_dly", 32'(bus.cur_delay), 8);
      chk("t4_err", 32'(bus.cfg_err),   1);
      idle();
      chk("t4_err_end", 32'(bus.cfg_err), 0);
      chk("t4_run",     32'(bus.busy),    0);
      for (int d = 111; d <= 114; d++) begin
         push(d);
         chk("t4_vld", 32'(bus.out_valid), 1);
         chk("t4_dat", 32'(bus.out_data),  32'(d - 8));
      end

      // Config accept coincident with a sample: that sample keeps the old delay
      bus.cfg_valid = 1'b1;
      bus.cfg_delay = 4'd0;
      push(115);
      bus.cfg_valid = 1'b0;
      chk("t5_vld", 32'(bus.out_valid), 1);
      chk("t5_dat", 32'(bus.out_data),  107);
      chk("t5_dly", 32'(bus.cur_delay), 0);
      push(116);
      chk("t5_apply_vld", 32'(bus.out_valid), 0);
      chk("t5_apply_dat", 32'(bus.out_data),  107);
      chk("t5_err",       32'(bus.cfg_err),   0);
      push(117);
      chk("t5_d0_vld", 32'(bus.out_valid), 1);
      chk("t5_d0_dat", 32'(bus.out_data),  117);

      // Asynchronous reset mid-stream
      push(118);
      chk("t6_pre", 32'(bus.out_data), 118);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'd119;
      #2;
      rst = 1'b0;
      #1;
      chk("t6_vld",  32'(bus.out_valid), 0);
      chk("t6_dat",  32'(bus.out_data),  0);
      chk("t6_dly",  32'(bus.cur_delay), 3);
      chk("t6_busy", 32'(bus.busy),      1);
      chk("t6_rdy",  32'(bus.cfg_ready), 1);
      tick();
      rst = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         push(299 + k);
         chk("t6_post_vld", 32'(bus.out_valid), 32'(k >= 4));
         if (k >= 4) chk("t6_post_dat", 32'(bus.out_data), 32'(296 + k));
      end
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
